// File: rtl/sram_arbiter_if.sv
// Requester-side bus for sram_arbiter: a level request held until the
// one-cycle ack, plus the latched command fields and the returned read data.
interface sram_arbiter_if #(
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 16
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and strobe sequencer for a 512Kx16 async SRAM.
// Every SRAM-side output and ack comes straight from a flop.
module sram_arbiter #(
    parameter int unsigned AW   = 19,
    parameter int unsigned DW   = 16,
    parameter int unsigned WAIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave p0,
    sram_arbiter_if.slave p1,
    output logic          busy,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_dat_o,
    output logic          ram_dat_oe,
    input  logic [DW-1:0] ram_dat_i,
    output logic          ram_cs_n,
    output logic          ram_oe_n,
    output logic          ram_we_n
);
    localparam int unsigned   CW   = 4;
    localparam logic [CW-1:0] LAST = CW'(WAIT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          last_grant;
    logic          we_q;

    logic sel_c;
    logic start_c;
    logic last_acc_c;
    logic txn_we_c;

    logic cs_n_d;
    logic oe_n_d;
    logic we_n_d;
    logic dat_oe_d;
    logic busy_d;
    logic ack0_d;
    logic ack1_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and grant selection; contention goes to the port not served last
    always_comb begin
        state_nxt  = state;
        sel_c      = 1'b0;
        start_c    = 1'b0;
        last_acc_c = (cnt == LAST);
        case (state)
            IDLE: begin
                if (p0.req || p1.req) begin
                    start_c   = 1'b1;
                    sel_c     = (p0.req && p1.req) ? ~last_grant : p1.req;
                    state_nxt = SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (last_acc_c) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe values for the state being entered, so they can be registered
    always_comb begin
        cs_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        txn_we_c = start_c ? (sel_c ? p1.we : p0.we) : we_q;
        case (state_nxt)
            SETUP: begin
                cs_n_d   = 1'b0;
                busy_d   = 1'b1;
                dat_oe_d = txn_we_c;
            end
            ACCESS: begin
                cs_n_d   = 1'b0;
                busy_d   = 1'b1;
                dat_oe_d = txn_we_c;
                oe_n_d   = txn_we_c;
                we_n_d   = ~txn_we_c;
            end
            HOLD: begin
                cs_n_d   = 1'b0;
                busy_d   = 1'b1;
                dat_oe_d = txn_we_c;
                ack0_d   = ~grant;
                ack1_d   = grant;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_cs_n   <= 1'b1;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            ram_dat_oe <= 1'b0;
            busy       <= 1'b0;
            p0.ack     <= 1'b0;
            p1.ack     <= 1'b0;
        end else begin
            ram_cs_n   <= cs_n_d;
            ram_oe_n   <= oe_n_d;
            ram_we_n   <= we_n_d;
            ram_dat_oe <= dat_oe_d;
            busy       <= busy_d;
            p0.ack     <= ack0_d;
            p1.ack     <= ack1_d;
        end
    end

    // Command latch at the grant edge; requesters may change fields afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            ram_adr    <= '0;
            ram_dat_o  <= '0;
        end else if (start_c) begin
            grant      <= sel_c;
            last_grant <= sel_c;
            we_q       <= txn_we_c;
            ram_adr    <= sel_c ? p1.addr : p0.addr;
            ram_dat_o  <= sel_c ? p1.wdata : p0.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              cnt <= '0;
        else if (state == ACCESS && !last_acc_c) cnt <= cnt + CW'(1);
        else                                  cnt <= '0;
    end

    // Read data captured on the edge that closes the last OE-low cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0.rdata <= '0;
            p1.rdata <= '0;
        end else if (state == ACCESS && last_acc_c && !we_q) begin
            if (grant) p1.rdata <= ram_dat_i;
            else       p0.rdata <= ram_dat_i;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a WAIT=2 and a WAIT=1 instance, each with its own
// SRAM model, driven by scenario tasks against an ack-ordered scoreboard.
module tb_sram_arbiter;
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Port index i = 2*inst + port; inst 0 is WAIT=2, inst 1 is WAIT=1
    sram_arbiter_if #(.AW(AW), .DW(DW)) pif [4] ();
    logic          req_d   [4];
    logic          we_d    [4];
    logic [AW-1:0] addr_d  [4];
    logic [DW-1:0] wdata_d [4];
    logic          ack_v   [4];
    logic [DW-1:0] rdata_v [4];

    for (genvar i = 0; i < 4; i++) begin : g_port
        assign pif[i].req   = req_d[i];
        assign pif[i].we    = we_d[i];
        assign pif[i].addr  = addr_d[i];
        assign pif[i].wdata = wdata_d[i];
        assign ack_v[i]     = pif[i].ack;
        assign rdata_v[i]   = pif[i].rdata;
    end

    logic          busy_v     [2];
    logic [AW-1:0] ram_adr    [2];
    logic [DW-1:0] ram_dat_o  [2];
    logic [DW-1:0] ram_dat_i  [2];
    logic          ram_dat_oe [2];
    logic          ram_cs_n   [2];
    logic          ram_oe_n   [2];
    logic          ram_we_n   [2];

    sram_arbiter #(.AW(AW), .DW(DW), .WAIT(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .p0(pif[0]), .p1(pif[1]), .busy(busy_v[0]),
        .ram_adr(ram_adr[0]), .ram_dat_o(ram_dat_o[0]), .ram_dat_oe(ram_dat_oe[0]),
        .ram_dat_i(ram_dat_i[0]), .ram_cs_n(ram_cs_n[0]), .ram_oe_n(ram_oe_n[0]),
        .ram_we_n(ram_we_n[0])
    );

    sram_arbiter #(.AW(AW), .DW(DW), .WAIT(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .p0(pif[2]), .p1(pif[3]), .busy(busy_v[1]),
        .ram_adr(ram_adr[1]), .ram_dat_o(ram_dat_o[1]), .ram_dat_oe(ram_dat_oe[1]),
        .ram_dat_i(ram_dat_i[1]), .ram_cs_n(ram_cs_n[1]), .ram_oe_n(ram_oe_n[1]),
        .ram_we_n(ram_we_n[1])
    );

    // SRAM models: write while CS and WE low with the bus driven, read while OE low
    logic [DW-1:0] mem [2][1 << AW];
    bit loaded;
    always @(posedge clk) begin
        if (!loaded) begin
            mem[0][19'h12345] <= 16'hBEEF;
            mem[1][19'h12345] <= 16'hBEEF;
            loaded <= 1'b1;
        end
        for (int k = 0; k < 2; k++)
            if (!ram_cs_n[k] && !ram_we_n[k] && ram_dat_oe[k]) mem[k][ram_adr[k]] <= ram_dat_o[k];
    end
    assign ram_dat_i[0] = (!ram_cs_n[0] && !ram_oe_n[0]) ? mem[0][ram_adr[0]] : 16'h0BAD;
    assign ram_dat_i[1] = (!ram_cs_n[1] && !ram_oe_n[1]) ? mem[1][ram_adr[1]] : 16'h0BAD;

    // Cumulative strobe statistics sampled mid-cycle
    int cyc;
    int cs_lo [2], oe_lo [2], we_lo [2], doe_hi [2];
    int overlap [2], rd_doe [2], adr_chg [2];
    int ack_cnt [4];
    logic          prev_cs_n [2];
    logic [AW-1:0] prev_adr  [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cs_lo[k]     <= cs_lo[k]   + int'(!ram_cs_n[k]);
            oe_lo[k]     <= oe_lo[k]   + int'(!ram_oe_n[k]);
            we_lo[k]     <= we_lo[k]   + int'(!ram_we_n[k]);
            doe_hi[k]    <= doe_hi[k]  + int'(ram_dat_oe[k]);
            overlap[k]   <= overlap[k] + int'(!ram_oe_n[k] && !ram_we_n[k]);
            rd_doe[k]    <= rd_doe[k]  + int'(!ram_oe_n[k] && ram_dat_oe[k]);
            adr_chg[k]   <= adr_chg[k] + int'(!ram_cs_n[k] && !prev_cs_n[k] && ram_adr[k] != prev_adr[k]);
            prev_cs_n[k] <= ram_cs_n[k];
            prev_adr[k]  <= ram_adr[k];
        end
        for (int i = 0; i < 4; i++) ack_cnt[i] <= ack_cnt[i] + int'(ack_v[i]);
    end

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          sb [$];
    int            errors;
    int            checks;
    int            ack_at [8];
    logic [AW-1:0] ack_adr;

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic issue(input int k, input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        txn_t e;
        int   i;
        i = 2 * k + p;
        e.port = p; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
        sb.push_back(e);
        if (!req_d[i]) begin
            we_d[i] = we; addr_d[i] = a; wdata_d[i] = wd; req_d[i] = 1'b1;
        end
    endtask

    // Waits for n acks on instance k, popping the scoreboard in service order
    task automatic collect(input int k, input int n, input bit keep, input int budget);
        int   got, t, g, lat, i;
        bit   found;
        logic pbusy;
        txn_t e;
        got = 0; t = 0; g = cyc;
        pbusy = busy_v[k];
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            if (busy_v[k] && !pbusy) g = cyc;
            pbusy = busy_v[k];
            for (int p = 0; p < 2; p++) begin
                i = 2 * k + p;
                if (ack_v[i]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_empty: inst %0d unexpected ack on port %0d", k, p);
                    end else begin
                        e = sb.pop_front();
                        if (p != e.port) begin
                            errors++;
                            $display("FAIL order: inst %0d ack from port %0d, expected port %0d", k, p, e.port);
                        end
                        if (!e.we) begin
                            checks++;
                            if (rdata_v[i] !== e.rdata) begin
                                errors++;
                                $display("FAIL rdata: inst %0d port %0d got %h want %h", k, p, rdata_v[i], e.rdata);
                            end
                        end
                        lat = cyc + 1 - g;
                        checks++;
                        if (lat != wait_of(k) + 2) begin
                            errors++;
                            $display("FAIL latency: inst %0d port %0d got %0d want %0d", k, p, lat, wait_of(k) + 2);
                        end
                    end
                    ack_at[got] = cyc;
                    ack_adr = ram_adr[k];
                    got++;
                    found = 1'b0;
                    if (keep) begin
                        foreach (sb[j]) begin
                            if (!found && sb[j].port == p) begin
                                found = 1'b1;
                                we_d[i] = sb[j].we; addr_d[i] = sb[j].addr; wdata_d[i] = sb[j].wdata;
                            end
                        end
                    end
                    if (!found) req_d[i] = 1'b0;
                end
            end
            if (got >= n) begin
                req_d[2 * k] = 1'b0;
                req_d[2 * k + 1] = 1'b0;
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL ack_timeout: inst %0d got %0d acks want %0d", k, got, n);
            req_d[2 * k] = 1'b0;
            req_d[2 * k + 1] = 1'b0;
            sb.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({ram_cs_n[k], ram_oe_n[k], ram_we_n[k], ram_dat_oe[k], busy_v[k]} !== 5'b11100) begin
                errors++;
                $display("FAIL reset_strobes: inst %0d cs/oe/we/doe/busy=%b want 11100", k,
                         {ram_cs_n[k], ram_oe_n[k], ram_we_n[k], ram_dat_oe[k], busy_v[k]});
            end
            checks++;
            if (ram_adr[k] !== '0 || ram_dat_o[k] !== '0) begin
                errors++;
                $display("FAIL reset_bus: inst %0d adr=%h dat_o=%h want 0", k, ram_adr[k], ram_dat_o[k]);
            end
            checks++;
            if ({ack_v[2*k], ack_v[2*k+1]} !== 2'b00 || rdata_v[2*k] !== '0 || rdata_v[2*k+1] !== '0) begin
                errors++;
                $display("FAIL reset_ports: inst %0d acks=%b rdata=%h/%h want 0", k,
                         {ack_v[2*k], ack_v[2*k+1]}, rdata_v[2*k], rdata_v[2*k+1]);
            end
        end
    endtask

    task automatic test_contention();
        @(negedge clk); #1;
        issue(0, 0, 1'b0, 19'h12345, 16'h0, 16'hBEEF);
        issue(0, 1, 1'b0, 19'h12345, 16'h0, 16'hBEEF);
        issue(0, 0, 1'b0, 19'h12345, 16'h0, 16'hBEEF);
        issue(0, 1, 1'b0, 19'h12345, 16'h0, 16'hBEEF);
        collect(0, 4, 1'b1, 60);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_read(input int k);
        int c0, o0, d0, a0;
        @(negedge clk); #1;
        c0 = cs_lo[k]; o0 = oe_lo[k]; d0 = doe_hi[k]; a0 = ack_cnt[2*k];
        issue(k, 0, 1'b0, 19'h12345, 16'h0, 16'hBEEF);
        collect(k, 1, 1'b0, 30);
        repeat (2) @(negedge clk); #1;
        checks++;
        if (cs_lo[k] - c0 != wait_of(k) + 2) begin
            errors++;
            $display("FAIL rd_cs_len: inst %0d got %0d want %0d", k, cs_lo[k] - c0, wait_of(k) + 2);
        end
        checks++;
        if (oe_lo[k] - o0 != wait_of(k)) begin
            errors++;
            $display("FAIL rd_oe_len: inst %0d got %0d want %0d", k, oe_lo[k] - o0, wait_of(k));
        end
        checks++;
        if (doe_hi[k] != d0) begin
            errors++;
            $display("FAIL rd_dat_oe: inst %0d got %0d cycles want 0", k, doe_hi[k] - d0);
        end
        checks++;
        if (ack_cnt[2*k] - a0 != 1) begin
            errors++;
            $display("FAIL rd_ack_pulse: inst %0d got %0d want 1", k, ack_cnt[2*k] - a0);
        end
        checks++;
        if (rdata_v[2*k] !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_stable: inst %0d got %h want beef", k, rdata_v[2*k]);
        end
    endtask

    task automatic test_single_write(input int k);
        int w0, o0, d0, a0, b0, x0;
        @(negedge clk); #1;
        w0 = we_lo[k]; o0 = oe_lo[k]; d0 = doe_hi[k]; a0 = ack_cnt[2*k]; b0 = ack_cnt[2*k+1];
        x0 = adr_chg[k];
        issue(k, 1, 1'b1, 19'h00001, 16'hA5A5, 16'h0);
        collect(k, 1, 1'b0, 30);
        repeat (2) @(negedge clk); #1;
        checks++;
        if (we_lo[k] - w0 != wait_of(k)) begin
            errors++;
            $display("FAIL wr_we_len: inst %0d got %0d want %0d", k, we_lo[k] - w0, wait_of(k));
        end
        checks++;
        if (doe_hi[k] - d0 != wait_of(k) + 2 || oe_lo[k] != o0) begin
            errors++;
            $display("FAIL wr_dat_oe: inst %0d doe=%0d oe=%0d want %0d/0", k, doe_hi[k] - d0,
                     oe_lo[k] - o0, wait_of(k) + 2);
        end
        checks++;
        if (adr_chg[k] != x0 || ack_adr !== 19'h00001) begin
            errors++;
            $display("FAIL wr_adr: inst %0d changes=%0d adr_at_ack=%h want 0/00001", k, adr_chg[k] - x0, ack_adr);
        end
        checks++;
        if (mem[k][19'h00001] !== 16'hA5A5) begin
            errors++;
            $display("FAIL wr_mem: inst %0d got %h want a5a5", k, mem[k][19'h00001]);
        end
        checks++;
        if (ack_cnt[2*k+1] - b0 != 1 || ack_cnt[2*k] != a0) begin
            errors++;
            $display("FAIL wr_acks: inst %0d p1=%0d p0=%0d want 1/0", k, ack_cnt[2*k+1] - b0, ack_cnt[2*k] - a0);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        @(negedge clk); #1;
        c0 = cs_lo[0];
        issue(0, 0, 1'b1, 19'h00000, 16'h1111, 16'h0);
        issue(0, 0, 1'b1, 19'h00001, 16'h2222, 16'h0);
        issue(0, 0, 1'b1, 19'h00002, 16'h3333, 16'h0);
        collect(0, 3, 1'b1, 60);
        repeat (2) @(negedge clk); #1;
        for (int j = 1; j < 3; j++) begin
            checks++;
            if (ack_at[j] - ack_at[j-1] != 5) begin
                errors++;
                $display("FAIL b2b_spacing: ack %0d gap %0d want 5", j, ack_at[j] - ack_at[j-1]);
            end
        end
        checks++;
        if (cs_lo[0] - c0 != 12) begin
            errors++;
            $display("FAIL b2b_cs_low: got %0d want 12", cs_lo[0] - c0);
        end
        checks++;
        if (mem[0][19'h0] !== 16'h1111 || mem[0][19'h1] !== 16'h2222 || mem[0][19'h2] !== 16'h3333) begin
            errors++;
            $display("FAIL b2b_mem: got %h %h %h want 1111 2222 3333", mem[0][19'h0], mem[0][19'h1], mem[0][19'h2]);
        end
    endtask

    task automatic test_reset_mid_write();
        int t;
        bit seen;
        t = 0; seen = 1'b0;
        @(negedge clk); #1;
        issue(0, 1, 1'b1, 19'h00077, 16'h5A5A, 16'h0);
        while (!seen && t < 20) begin
            @(negedge clk);
            t++;
            if (!ram_we_n[0]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_we_seen: ram_we_n never low within %0d cycles", t);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_we_n[0], ram_cs_n[0], ram_dat_oe[0], busy_v[0], ack_v[0], ack_v[1]} !== 6'b110000) begin
            errors++;
            $display("FAIL mid_reset: we_n/cs_n/doe/busy/ack0/ack1=%b want 110000",
                     {ram_we_n[0], ram_cs_n[0], ram_dat_oe[0], busy_v[0], ack_v[0], ack_v[1]});
        end
        sb.delete();
        for (int i = 0; i < 4; i++) req_d[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        issue(0, 0, 1'b0, 19'h12345, 16'h0, 16'hBEEF);
        issue(0, 1, 1'b1, 19'h00010, 16'hC3C3, 16'h0);
        collect(0, 2, 1'b0, 40);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_overlap();
        @(negedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (overlap[k] != 0) begin
                errors++;
                $display("FAIL oe_we_overlap: inst %0d got %0d cycles want 0", k, overlap[k]);
            end
            checks++;
            if (rd_doe[k] != 0) begin
                errors++;
                $display("FAIL oe_with_dat_oe: inst %0d got %0d cycles want 0", k, rd_doe[k]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            req_d[i] = 1'b0; we_d[i] = 1'b0; addr_d[i] = '0; wdata_d[i] = '0;
        end
        errors = 0;
        checks = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_contention();
        test_single_read(0);
        test_single_write(0);
        test_back_to_back();
        test_reset_mid_write();
        test_single_read(1);
        test_single_write(1);
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
